// File: rtl/dcache_req_unit.sv
// rtl/dcache_req_unit.sv - MEM-stage data-cache initiator: aligns stores, issues cache requests, captures raw load data.
module dcache_req_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] rs2_out,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wmask,
  output logic        stall,
  output logic        done_valid,
  output logic [31:0] mdrreg_out,
  output logic [3:0]  rmask,
  output logic        bad_access
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [3:0]  pend_rmask;
  logic        mem_op;
  logic        is_load;
  logic        align_ok;
  logic        f3_ok;
  logic        accept;
  logic [3:0]  byte_mask;
  logic [31:0] aligned_wdata;

  always_comb begin
    mem_op  = req_valid & (req_load | req_store);
    // A request flagged as both load and store is handled as a load.
    is_load = req_load;

    align_ok = 1'b1;
    case (funct3[1:0])
      2'b01:   align_ok = ~addr[0];
      2'b10:   align_ok = (addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase

    if (is_load)
      f3_ok = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else
      f3_ok = funct3 inside {3'b000, 3'b001, 3'b010};

    bad_access = mem_op & ~(align_ok & f3_ok);

    byte_mask     = 4'b1111;
    aligned_wdata = rs2_out;
    case (funct3[1:0])
      2'b00: begin
        byte_mask     = 4'b0001 << addr[1:0];
        aligned_wdata = {4{rs2_out[7:0]}};
      end
      2'b01: begin
        byte_mask     = 4'b0011 << {addr[1], 1'b0};
        aligned_wdata = {2{rs2_out[15:0]}};
      end
      default: begin
        byte_mask     = 4'b1111;
        aligned_wdata = rs2_out;
      end
    endcase

    accept = (state == IDLE) & mem_op & ~bad_access;
    stall  = accept | (state == BUSY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      dmem_read    <= 1'b0;
      dmem_write   <= 1'b0;
      dmem_address <= 32'h0;
      dmem_wdata   <= 32'h0;
      dmem_wmask   <= 4'h0;
      pend_rmask   <= 4'h0;
      done_valid   <= 1'b0;
      mdrreg_out   <= 32'h0;
      rmask        <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dmem_address <= {addr[31:2], 2'b00};
            dmem_wdata   <= is_load ? 32'h0 : aligned_wdata;
            dmem_wmask   <= is_load ? 4'h0 : byte_mask;
            pend_rmask   <= byte_mask;
            dmem_read    <= is_load;
            dmem_write   <= ~is_load;
            state        <= BUSY;
          end
        end
        BUSY: begin
          if (dmem_resp) begin
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            done_valid <= 1'b1;
            // dmem_read is still high here, so it identifies the access kind.
            if (dmem_read) begin
              mdrreg_out <= dmem_rdata;
              rmask      <= pend_rmask;
            end else begin
              rmask      <= 4'h0;
            end
            state <= DONE;
          end
        end
        DONE: begin
          done_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_req_unit.sv
// tb/tb_dcache_req_unit.sv - directed self-checking bench for dcache_req_unit with a transaction-level model.
module tb_dcache_req_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_load, req_store;
  logic [2:0]  funct3;
  logic [31:0] addr, rs2_out, dmem_rdata;
  logic        dmem_resp;
  logic        dmem_read, dmem_write;
  logic [31:0] dmem_address, dmem_wdata;
  logic [3:0]  dmem_wmask;
  logic        stall, done_valid;
  logic [31:0] mdrreg_out;
  logic [3:0]  rmask;
  logic        bad_access;

  dcache_req_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_load(req_load),
    .req_store(req_store), .funct3(funct3), .addr(addr), .rs2_out(rs2_out),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
    .dmem_wmask(dmem_wmask), .stall(stall), .done_valid(done_valid),
    .mdrreg_out(mdrreg_out), .rmask(rmask), .bad_access(bad_access)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int stall_cnt, write_cnt, read_cnt, done_cnt;

  logic        e_read, e_write, e_stall, e_done;
  logic [31:0] e_addr, e_wdata, e_mdr;
  logic [3:0]  e_wmask, e_rmask;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int f_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic f_bad(input logic v, input logic ld, input logic st,
                                 input logic [2:0] f3, input logic [31:0] a);
    int off;
    if (!(v && (ld || st))) return 1'b0;
    off = int'(a[1:0]);
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
    if (!ld && f3[2]) return 1'b1;
    if ((off % f_size(f3)) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] f_mask(input logic [2:0] f3, input logic [31:0] a);
    int n, base;
    n    = f_size(f3);
    base = (int'(a[1:0]) / n) * n;
    return 4'(((1 << n) - 1) << base);
  endfunction

  function automatic logic [31:0] f_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    int n;
    n = f_size(f3);
    r = 32'h0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("dmem_read", {31'h0, dmem_read}, {31'h0, e_read});
      check("dmem_write", {31'h0, dmem_write}, {31'h0, e_write});
      check("dmem_address", dmem_address, e_addr);
      check("dmem_wdata", dmem_wdata, e_wdata);
      check("dmem_wmask", {28'h0, dmem_wmask}, {28'h0, e_wmask});
      check("stall", {31'h0, stall}, {31'h0, e_stall});
      check("done_valid", {31'h0, done_valid}, {31'h0, e_done});
      check("mdrreg_out", mdrreg_out, e_mdr);
      check("rmask", {28'h0, rmask}, {28'h0, e_rmask});
      check("bad_access", {31'h0, bad_access},
            {31'h0, f_bad(req_valid, req_load, req_store, funct3, addr)});
      if (stall === 1'b1) stall_cnt++;
      if (dmem_write === 1'b1) write_cnt++;
      if (dmem_read === 1'b1) read_cnt++;
      if (done_valid === 1'b1) done_cnt++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    req_valid = v; req_load = ld; req_store = st; funct3 = f3; addr = a; rs2_out = d;
  endtask

  task automatic clear_counts;
    stall_cnt = 0; write_cnt = 0; read_cnt = 0; done_cnt = 0;
  endtask

  task automatic do_op(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input int lat,
                       input logic [31:0] rd, input bit stray);
    logic [3:0] m;
    m = f_mask(f3, a);
    tick;
    drive(1'b1, ld, st, f3, a, d);
    dmem_resp = stray; dmem_rdata = 32'hDEADBEEF;
    e_read = 1'b0; e_write = 1'b0; e_done = 1'b0; e_stall = 1'b1;
    for (int c = 1; c <= lat; c++) begin
      tick;
      dmem_resp = (c == lat); dmem_rdata = rd;
      e_read = ld; e_write = !ld; e_stall = 1'b1;
      e_addr = {a[31:2], 2'b00};
      e_wdata = ld ? 32'h0 : f_wdata(f3, d);
      e_wmask = ld ? 4'h0 : m;
    end
    tick;
    dmem_resp = 1'b0; dmem_rdata = 32'h0;
    e_read = 1'b0; e_write = 1'b0; e_done = 1'b1; e_stall = 1'b0;
    if (ld) begin
      e_mdr = rd; e_rmask = m;
    end else begin
      e_rmask = 4'h0;
    end
  endtask

  task automatic pass_op(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a);
    tick;
    drive(v, ld, st, f3, a, 32'h13572468);
    dmem_resp = 1'b0;
    e_read = 1'b0; e_write = 1'b0; e_done = 1'b0; e_stall = 1'b0;
  endtask

  task automatic idle(input int n, input logic resp);
    for (int i = 0; i < n; i++) begin
      tick;
      drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      dmem_resp = resp; dmem_rdata = 32'hF00DF00D;
      e_read = 1'b0; e_write = 1'b0; e_done = 1'b0; e_stall = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    dmem_resp = 1'b0; dmem_rdata = 32'h0;
    e_read = 0; e_write = 0; e_stall = 0; e_done = 0;
    e_addr = 0; e_wdata = 0; e_mdr = 0; e_wmask = 0; e_rmask = 0;
    clear_counts();
    tick;
    chk_en = 1'b1;
    tick;
    rst = 1'b0;
    idle(2, 1'b1);

    // sb at 0x1003, response three cycles after the request goes out
    clear_counts();
    do_op(1'b0, 1'b1, 3'b000, 32'h00001003, 32'hAABBCC5E, 3, 32'h0, 1'b0);
    idle(1, 1'b0);
    check("sb_address", dmem_address, 32'h00001000);
    check("sb_wmask", {28'h0, dmem_wmask}, 32'h8);
    check("sb_wdata", dmem_wdata, 32'h5E5E5E5E);
    check("sb_rmask", {28'h0, rmask}, 32'h0);
    check("sb_stall_cycles", stall_cnt, 4);
    check("sb_write_cycles", write_cnt, 3);
    check("sb_done_pulses", done_cnt, 1);

    // lh at 0x2006 with immediate response
    clear_counts();
    do_op(1'b1, 1'b0, 3'b001, 32'h00002006, 32'h0, 1, 32'h80017FFF, 1'b0);
    idle(1, 1'b0);
    check("lh_mdr", mdrreg_out, 32'h80017FFF);
    check("lh_rmask", {28'h0, rmask}, 32'hC);
    check("lh_read_cycles", read_cnt, 1);
    check("lh_stall_cycles", stall_cnt, 2);

    // misaligned and illegal accesses are rejected without cache traffic
    clear_counts();
    pass_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h00003002);
    #1;
    check("lw_mis_bad", {31'h0, bad_access}, 32'h1);
    check("lw_mis_stall", {31'h0, stall}, 32'h0);
    pass_op(1'b1, 1'b0, 1'b1, 3'b001, 32'h00003001);
    #1;
    check("sh_mis_bad", {31'h0, bad_access}, 32'h1);
    pass_op(1'b1, 1'b1, 1'b0, 3'b011, 32'h00000000);
    pass_op(1'b1, 1'b0, 1'b1, 3'b100, 32'h00000000);
    pass_op(1'b1, 1'b0, 1'b0, 3'b010, 32'h00000000);
    pass_op(1'b0, 1'b1, 1'b0, 3'b010, 32'h00000001);
    idle(1, 1'b0);
    check("bad_no_traffic", read_cnt + write_cnt + stall_cnt, 0);

    // sh at 0x3002, lbu with load+store both set, lw
    do_op(1'b0, 1'b1, 3'b001, 32'h00003002, 32'h0000ABCD, 1, 32'h0, 1'b0);
    idle(1, 1'b0);
    check("sh_wdata", dmem_wdata, 32'hABCDABCD);
    check("sh_wmask", {28'h0, dmem_wmask}, 32'hC);
    do_op(1'b1, 1'b1, 3'b100, 32'h00000041, 32'h0, 2, 32'h11223344, 1'b0);
    idle(1, 1'b0);
    check("lbu_rmask", {28'h0, rmask}, 32'h2);
    do_op(1'b1, 1'b0, 3'b010, 32'h00000080, 32'h0, 4, 32'h0BADC0DE, 1'b0);

    // reset while BUSY, then a late response
    tick;
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h00000040, 32'h0);
    e_done = 1'b0; e_stall = 1'b1; e_read = 1'b0; e_write = 1'b0;
    tick;
    e_read = 1'b1; e_addr = 32'h40; e_wdata = 32'h0; e_wmask = 4'h0; e_stall = 1'b1;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    dmem_resp = 1'b1; dmem_rdata = 32'h12345678;
    e_read = 0; e_write = 0; e_stall = 0; e_done = 0;
    e_addr = 0; e_wdata = 0; e_mdr = 0; e_wmask = 0; e_rmask = 0;
    clear_counts();
    idle(2, 1'b0);
    check("rst_mdr", mdrreg_out, 32'h0);
    check("rst_no_done", done_cnt, 0);

    // back-to-back sw then lw, with a stray response in the lw's accept cycle
    do_op(1'b0, 1'b1, 3'b010, 32'h00000010, 32'hCAFEF00D, 2, 32'h0, 1'b0);
    do_op(1'b1, 1'b0, 3'b010, 32'h00000010, 32'h0, 2, 32'hCAFEF00D, 1'b1);
    idle(1, 1'b0);
    check("b2b_mdr", mdrreg_out, 32'hCAFEF00D);
    check("b2b_rmask", {28'h0, rmask}, 32'hF);
    idle(2, 1'b0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dcache_req_unit.md
# dcache_req_unit

Memory-stage data-cache initiator for the RV32I pipeline. Accepts a load or store from MEM, aligns store data and byte masks, drives the data-cache read/write handshake, and stalls the pipeline until the response arrives. Load data is captured unmodified as `mdrreg_out`, together with its `rmask`. WB later sign/zero-extends and byte-selects that data. This block is the writer side of the `mdrreg_out`/`rmask` pair that WB reads.

## Interface
- No parameters; data and address are fixed at 32 bits (`rv32i_word`).
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: MEM holds a valid instruction.
- `req_load` in 1: instruction is a load.
- `req_store` in 1: instruction is a store.
- `funct3` in 3: access size/sign. 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `addr` in 32: effective address (`alu_out`).
- `rs2_out` in 32: store source data.
- `dmem_rdata` in 32: cache read data, valid with `dmem_resp`.
- `dmem_resp` in 1: cache completion, one-cycle pulse.
- `dmem_read` out 1: registered read request.
- `dmem_write` out 1: registered write request.
- `dmem_address` out 32: registered, `{addr[31:2], 2'b00}`.
- `dmem_wdata` out 32: registered, aligned store data.
- `dmem_wmask` out 4: registered byte write enables.
- `stall` out 1: combinational; freezes IF–MEM.
- `done_valid` out 1: registered; access completed this cycle.
- `mdrreg_out` out 32: registered raw load word.
- `rmask` out 4: registered load byte mask.
- `bad_access` out 1: combinational; misaligned access or illegal `funct3`.

## Operation
- Memory op: `mem_op = req_valid & (req_load | req_store)`. If both `req_load` and `req_store` are set, the access is treated as a load.
- `bad_access` is asserted, and no access is issued, for any of:
  - halfword with `addr[0]=1`;
  - word with `addr[1:0]≠0`;
  - load `funct3` ∈ {011, 110, 111};
  - store `funct3` ∉ {000, 001, 010}.
- Store alignment (`o = addr[1:0]`):
  - sb: `wmask = 4'b0001 << o`, `wdata = {4{rs2_out[7:0]}}`.
  - sh: `wmask = 4'b0011 << {addr[1],1'b0}`, `wdata = {2{rs2_out[15:0]}}`.
  - sw: `wmask = 4'b1111`, `wdata = rs2_out`.
- Load mask:
  - b/bu: `0001 << o`.
  - h/hu: `0011 << {addr[1],0}`.
  - w: `1111`.
  - Loads drive `dmem_wmask = 0`.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: on `mem_op & ~bad_access`, register address, wdata, wmask and pending rmask; set `dmem_read` or `dmem_write`; go to BUSY. Otherwise stay in IDLE.
  - BUSY: hold all `dmem_*` outputs stable. On `dmem_resp`:
    - clear `dmem_read`/`dmem_write`;
    - for a load, `mdrreg_out <= dmem_rdata` and `rmask <=` pending mask;
    - for a store, `mdrreg_out` is unchanged and `rmask <= 0`;
    - go to DONE.
  - DONE: `done_valid=1`, `stall=0`; unconditionally go to IDLE. `req_*` inputs are ignored in this state; they still belong to the retiring instruction.
- `stall = (IDLE & mem_op & ~bad_access) | BUSY`.
- `dmem_resp` outside BUSY is ignored.
- `mdrreg_out` holds its value until the next load completes.

## Timing
- Reset values:
  - state IDLE;
  - `dmem_read`, `dmem_write`, `dmem_address`, `dmem_wdata`, `dmem_wmask` all 0;
  - `done_valid`, `mdrreg_out`, `rmask` all 0.
- Reset during BUSY: requests drop on the next cycle. A late `dmem_resp` after reset is ignored.
- Minimum latency: request seen in IDLE at cycle 0; `dmem_read`/`dmem_write` high in cycle 1. If `dmem_resp` arrives in cycle 1, DONE is in cycle 2. `stall` is high in cycles 0–1; `done_valid` is high in cycle 2 only.
- In general, `stall` stays high from the accept cycle through the `dmem_resp` cycle inclusive.
- Back-to-back memory ops: the next op is accepted in the IDLE cycle after DONE. This gives one bubble-free handoff.
- Non-memory and `bad_access` instructions pass with `stall=0` and no `dmem_*` activity.

## Test plan
- Store byte: sb, `addr=0x1003`, `rs2_out=0xAABBCC5E`, resp after 3 cycles → `dmem_address=0x1000`, `wmask=1000`, `wdata=0x5E5E5E5E`, `dmem_write` high 3 cycles, `stall` high 4 cycles, `done_valid` one pulse, `rmask=0`.
- Load halfword: lh, `addr=0x2006`, `dmem_rdata=0x8001_7FFF` with immediate resp → `dmem_read` 1 cycle, DONE in cycle 2, `mdrreg_out=0x80017FFF`, `rmask=1100`.
- Misaligned: lw at `addr=0x3002` → `bad_access=1`, `stall=0`, no `dmem_read`; same result for sh at `0x3001`.
- Reset mid-flight: lw accepted, `rst` asserted while in BUSY, then `dmem_resp` arrives → `dmem_read=0` the cycle after reset, `mdrreg_out` stays 0, no `done_valid`.
- Back-to-back: sw `0x10` then lw `0x10`, each with a 2-cycle response → the lw issues in the cycle after the sw's DONE, `dmem_resp` arriving in IDLE is ignored, and the captured `mdrreg_out` matches `dmem_rdata`.
